// File: rtl/wb_sequencer.sv
// Writeback sequencer: takes one retiring op at a time, runs the bounded data-memory
// handshake, then drives the writeback select and register-file write strobe.
//
//   state | meaning
//   IDLE  | ready for the next op from execute
//   MEM   | data-memory request outstanding, timeout counter running
//   WB    | one-cycle register-file write
module wb_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  issue_kind,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_addr,
  input  logic [31:0] issue_wdata,
  input  logic [31:0] alu_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  result_sel,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy_valid,
  output logic [4:0]  busy_rd,
  output logic        mem_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] KIND_ALU   = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;

  localparam logic [1:0] SEL_READ_DATA  = 2'd1;
  localparam logic [1:0] SEL_ALU_RESULT = 2'd3;

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      issue_ready <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      result_sel  <= SEL_ALU_RESULT;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      busy_valid  <= 1'b0;
      busy_rd     <= '0;
      mem_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            case (issue_kind)
              KIND_ALU: begin
                if (issue_rd != 5'd0) begin
                  state       <= WB;
                  issue_ready <= 1'b0;
                  rf_we       <= 1'b1;
                  rf_waddr    <= issue_rd;
                  rf_wdata    <= alu_result;
                  result_sel  <= SEL_ALU_RESULT;
                  busy_valid  <= 1'b1;
                  busy_rd     <= issue_rd;
                end
              end
              KIND_LOAD: begin
                state       <= MEM;
                cnt         <= '0;
                issue_ready <= 1'b0;
                mem_req     <= 1'b1;
                mem_we      <= 1'b0;
                mem_addr    <= issue_addr;
                if (issue_rd != 5'd0) begin
                  busy_valid <= 1'b1;
                  busy_rd    <= issue_rd;
                end
              end
              KIND_STORE: begin
                state       <= MEM;
                cnt         <= '0;
                issue_ready <= 1'b0;
                mem_req     <= 1'b1;
                mem_we      <= 1'b1;
                mem_addr    <= issue_addr;
                mem_wdata   <= issue_wdata;
              end
              default: ;
            endcase
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            // busy_valid doubles as "load with a real destination" here
            if (!mem_we && busy_valid) begin
              state      <= WB;
              rf_we      <= 1'b1;
              rf_waddr   <= busy_rd;
              rf_wdata   <= mem_rdata;
              result_sel <= SEL_READ_DATA;
            end else begin
              state       <= IDLE;
              issue_ready <= 1'b1;
            end
          end else if (cnt == LAST) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_err     <= 1'b1;
            busy_valid  <= 1'b0;
            issue_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB: begin
          state       <= IDLE;
          rf_we       <= 1'b0;
          busy_valid  <= 1'b0;
          issue_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: drives ops with scheduled acks and compares every cycle
// of every output against a trace built from the timing rules of the sequencer.
module tb_wb_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [1:0]  issue_kind = '0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] issue_addr = '0;
  logic [31:0] issue_wdata = '0;
  logic [31:0] alu_result = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  result_sel;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy_valid;
  logic [4:0]  busy_rd;
  logic        mem_err;

  wb_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Reset(Reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_kind(issue_kind),
    .issue_rd(issue_rd), .issue_addr(issue_addr), .issue_wdata(issue_wdata),
    .alu_result(alu_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .result_sel(result_sel), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_valid(busy_valid), .busy_rd(busy_rd), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  rsel;
    logic        rfwe;
    logic [4:0]  waddr;
    logic [31:0] rfdata;
    logic        bv;
    logic [4:0]  brd;
    logic        err;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  obs_t mdl;
  obs_t exp_q[$];
  obs_t obs_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t s;
    s.ready = issue_ready; s.req = mem_req; s.we = mem_we;
    s.addr = mem_addr; s.wdata = mem_wdata; s.rsel = result_sel;
    s.rfwe = rf_we; s.waddr = rf_waddr; s.rfdata = rf_wdata;
    s.bv = busy_valid; s.brd = busy_rd; s.err = mem_err;
    return s;
  endfunction

  function automatic obs_t reset_obs();
    obs_t s;
    s = '0;
    s.ready = 1'b1;
    s.rsel = 2'd3;
    return s;
  endfunction

  // Expected per-cycle trace: entry 0 is the accepting cycle, the last entry is IDLE again.
  // ack_cyc is the request cycle (1-based) carrying mem_ack; beyond TIMEOUT means no ack.
  task automatic model_op(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] alu, input int ack_cyc,
                          input logic [31:0] rdata);
    obs_t e;
    int   n;
    exp_q.delete();
    e = mdl;
    exp_q.push_back(e);
    if (kind == 2'd0 && rd != 0) begin
      e.ready = 0; e.rfwe = 1; e.waddr = rd; e.rfdata = alu; e.rsel = 2'd3; e.bv = 1; e.brd = rd;
      exp_q.push_back(e);
      e.ready = 1; e.rfwe = 0; e.bv = 0;
      exp_q.push_back(e);
    end else if (kind == 2'd1 || kind == 2'd2) begin
      e.ready = 0; e.req = 1; e.we = (kind == 2'd2); e.addr = addr;
      if (kind == 2'd2) e.wdata = wdata;
      if (kind == 2'd1 && rd != 0) begin e.bv = 1; e.brd = rd; end
      n = (ack_cyc <= TIMEOUT) ? ack_cyc : TIMEOUT;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
      e.req = 0;
      if (ack_cyc > TIMEOUT) begin
        e.err = 1; e.bv = 0; e.ready = 1;
        exp_q.push_back(e);
      end else if (kind == 2'd1 && rd != 0) begin
        e.rfwe = 1; e.waddr = rd; e.rfdata = rdata; e.rsel = 2'd1;
        exp_q.push_back(e);
        e.rfwe = 0; e.bv = 0; e.ready = 1;
        exp_q.push_back(e);
      end else begin
        e.ready = 1;
        exp_q.push_back(e);
      end
    end else begin
      exp_q.push_back(e);
    end
    mdl = e;
  endtask

  // Drives one op (stray_ack raises mem_ack in the accepting cycle) and records outputs.
  task automatic apply_op(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] alu, input int ack_cyc,
                          input logic [31:0] rdata, input logic stray_ack);
    model_op(kind, rd, addr, wdata, alu, ack_cyc, rdata);
    obs_q.delete();
    obs_q.push_back(sample());
    issue_valid = 1; issue_kind = kind; issue_rd = rd; issue_addr = addr;
    issue_wdata = wdata; alu_result = alu; mem_rdata = rdata; mem_ack = stray_ack;
    for (int k = 1; k < exp_q.size(); k++) begin
      tick();
      issue_valid = 0;
      issue_kind = 2'($urandom); issue_rd = 5'($urandom);
      issue_addr = $urandom; issue_wdata = $urandom; alu_result = $urandom;
      mem_ack = (k == ack_cyc);
      obs_q.push_back(sample());
    end
    mem_ack = 0;
  endtask

  task automatic test_reset();
    obs_t o;
    Reset = 1;
    tick();
    tick();
    Reset = 0;
    o = sample();
    checks++;
    if (o !== reset_obs()) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", o, reset_obs());
    end
    mdl = reset_obs();
  endtask

  task automatic test_alu();
    apply_op(2'd0, 5'd5, 32'h0, 32'h0, 32'h1234, 0, 32'h0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL alu_rd5 cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_load();
    apply_op(2'd1, 5'd7, 32'h100, 32'h0, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL load_rd7 cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_store();
    apply_op(2'd2, 5'd3, 32'h40, 32'hA5A5A5A5, 32'h0, 1, 32'h0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL store_ack1 cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    apply_op(2'd1, 5'd9, 32'h200, 32'h0, 32'h0, TIMEOUT + 1, 32'h0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL load_timeout cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    apply_op(2'd1, 5'd10, 32'h204, 32'h0, 32'h0, TIMEOUT, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL load_ack_last cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_idle_ignore();
    apply_op(2'd0, 5'd0, 32'h0, 32'h0, 32'h5555AAAA, 0, 32'h12345678, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL alu_rd0_stray_ack cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    apply_op(2'd3, 5'd12, 32'h300, 32'h1, 32'h2, 0, 32'h3, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL nop cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      apply_op(2'd0, 5'(n + 1), 32'h0, 32'h0, $urandom, 0, 32'h0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL back_to_back op %0d cycle %0d: got %h expected %h", n, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] kind;
    logic [4:0] rd;
    int         ack_cyc;
    for (int n = 0; n < 40; n++) begin
      kind    = 2'($urandom_range(0, 3));
      rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ack_cyc = $urandom_range(1, TIMEOUT + 2);
      apply_op(kind, rd, $urandom, $urandom, $urandom, ack_cyc, $urandom, 1'($urandom));
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random op %0d kind %0d rd %0d ack %0d cycle %0d: got %h expected %h",
                   n, kind, rd, ack_cyc, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    obs_t o;
    issue_valid = 1; issue_kind = 2'd1; issue_rd = 5'd9; issue_addr = 32'h500;
    tick();
    issue_valid = 0;
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_mem_req_before: got %b expected 1", mem_req);
    end
    mem_ack = 1; mem_rdata = 32'hBAD0BAD0; Reset = 1;
    tick();
    mem_ack = 0; Reset = 0;
    for (int k = 0; k < 2; k++) begin
      o = sample();
      checks++;
      if (o !== reset_obs()) begin
        errors++;
        $display("FAIL reset_mid_mem cycle %0d: got %h expected %h", k, o, reset_obs());
      end
      tick();
    end
    mdl = reset_obs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_idle_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid_mem();
    test_alu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
